// File: rtl/text_console_pkg.sv
// Shared types and character codes for the text console controller.
package text_console_pkg;

    typedef enum logic [2:0] {IDLE, PUT, SCROLL, CLR_ROW, CLR_ALL} state_t;
    typedef enum logic [2:0] {CUR_NONE, CUR_ADV, CUR_NL, CUR_CR, CUR_BS, CUR_HOME} cur_cmd_t;

    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte stream in, character RAM port B out.
interface text_console_if #(parameter int AW = 12);
    logic          ch_valid;
    logic [7:0]    ch_data;
    logic          ch_ready;
    logic [AW-1:0] wraddress;
    logic [7:0]    data;
    logic          wren;
    logic [7:0]    q;

    modport master (output ch_valid, ch_data, q, input ch_ready, wraddress, data, wren);
    modport slave  (input ch_valid, ch_data, q, output ch_ready, wraddress, data, wren);
endinterface

// File: rtl/text_console_cursor.sv
// Cursor position plus row base address (y*COLS kept incrementally, no multiplier).
module console_cursor
    import text_console_pkg::*;
#(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  cur_cmd_t      cmd,
    output logic [6:0]    x,
    output logic [4:0]    y,
    output logic [AW-1:0] row_base,
    output logic          wrap
);
    localparam logic [6:0]    X_LAST = 7'(COLS - 1);
    localparam logic [4:0]    Y_LAST = 5'(ROWS - 1);
    localparam logic [AW-1:0] COLS_A = AW'(COLS);

    // Command would push the cursor below the last row; y itself saturates.
    assign wrap = (y == Y_LAST) && (((cmd == CUR_ADV) && (x == X_LAST)) || (cmd == CUR_NL));

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else begin
            case (cmd)
                CUR_ADV: begin
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y != Y_LAST) begin
                            y        <= y + 5'd1;
                            row_base <= row_base + COLS_A;
                        end
                    end else begin
                        x <= x + 7'd1;
                    end
                end
                CUR_NL: begin
                    x <= '0;
                    if (y != Y_LAST) begin
                        y        <= y + 5'd1;
                        row_base <= row_base + COLS_A;
                    end
                end
                CUR_CR: x <= '0;
                CUR_BS: begin
                    if (x != '0) begin
                        x <= x - 7'd1;
                    end else if (y != '0) begin
                        x        <= X_LAST;
                        y        <= y - 5'd1;
                        row_base <= row_base - COLS_A;
                    end
                end
                CUR_HOME: begin
                    x        <= '0;
                    y        <= '0;
                    row_base <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/text_console_ctrl.sv
// Character-stream controller: interprets bytes, drives port B of the character RAM
// for single-cell writes, one-row scroll copies and screen clears.
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          reset,
    text_console_if.slave bus,
    output logic [6:0]    cursor_x,
    output logic [4:0]    cursor_y,
    output logic          busy
);
    localparam logic [AW-1:0] COLS_A  = AW'(COLS);
    localparam logic [AW-1:0] TOTAL_A = AW'(COLS * ROWS);
    localparam logic [AW-1:0] N_A     = AW'(COLS * (ROWS - 1));
    localparam logic [AW-1:0] N_LAST  = AW'(COLS * (ROWS - 1) - 1);

    state_t        state;
    cur_cmd_t      cmd;
    logic          accept, wrap, wrap_pend;
    logic [AW-1:0] row_base, cur_addr;
    logic [AW-1:0] addr_r, src, dst, clr_addr;
    logic [7:0]    data_r, hold;
    logic          wren_r, slot, rd_now, hold_vld;

    assign accept        = (state == IDLE) && bus.ch_valid;
    assign cur_addr      = row_base + AW'(cursor_x);
    assign bus.ch_ready  = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.wraddress = addr_r;
    assign bus.data      = data_r;
    assign bus.wren      = wren_r;

    always_comb begin
        cmd = CUR_NONE;
        if (accept) begin
            if (is_printable(bus.ch_data)) begin
                cmd = CUR_ADV;
            end else begin
                case (bus.ch_data)
                    CH_CR:   cmd = CUR_CR;
                    CH_LF:   cmd = CUR_NL;
                    CH_BS:   cmd = CUR_BS;
                    CH_FF:   cmd = CUR_HOME;
                    default: cmd = CUR_NONE;
                endcase
            end
        end
    end

    console_cursor #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .cmd      (cmd),
        .x        (cursor_x),
        .y        (cursor_y),
        .row_base (row_base),
        .wrap     (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLR_ALL;
            clr_addr  <= '0;
            wren_r    <= 1'b0;
            addr_r    <= '0;
            data_r    <= '0;
            src       <= COLS_A;
            dst       <= '0;
            slot      <= 1'b1;
            rd_now    <= 1'b0;
            hold      <= '0;
            hold_vld  <= 1'b0;
            wrap_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Sequencer setup is refreshed while idle so any exit starts clean.
                    wren_r   <= 1'b0;
                    src      <= COLS_A;
                    dst      <= '0;
                    slot     <= 1'b1;
                    rd_now   <= 1'b0;
                    hold_vld <= 1'b0;
                    clr_addr <= '0;
                    if (accept) begin
                        if (is_printable(bus.ch_data)) begin
                            state     <= PUT;
                            wren_r    <= 1'b1;
                            addr_r    <= cur_addr;
                            data_r    <= bus.ch_data;
                            wrap_pend <= wrap;
                        end else begin
                            case (bus.ch_data)
                                CH_BS: if ((cursor_x != '0) || (cursor_y != '0)) begin
                                    // New position is always one cell back, even across rows.
                                    state     <= PUT;
                                    wren_r    <= 1'b1;
                                    addr_r    <= cur_addr - AW'(1);
                                    data_r    <= '0;
                                    wrap_pend <= 1'b0;
                                end
                                CH_LF:   if (wrap) state <= SCROLL;
                                CH_FF:   state <= CLR_ALL;
                                default: ;
                            endcase
                        end
                    end
                end
                PUT: begin
                    wren_r <= 1'b0;
                    state  <= wrap_pend ? SCROLL : IDLE;
                end
                SCROLL: begin
                    if (!slot) begin
                        // Write slot: store the cell captured on the previous read.
                        slot   <= 1'b1;
                        wren_r <= hold_vld;
                        addr_r <= dst;
                        data_r <= hold;
                        if (hold_vld) begin
                            dst <= dst + AW'(1);
                            if (dst == N_LAST) begin
                                state    <= CLR_ROW;
                                clr_addr <= N_A;
                            end
                        end
                    end else begin
                        // Read slot: q now holds data for the read issued two edges ago.
                        slot     <= 1'b0;
                        hold     <= bus.q;
                        hold_vld <= rd_now;
                        wren_r   <= 1'b0;
                        if (src != TOTAL_A) begin
                            addr_r <= src;
                            src    <= src + AW'(1);
                            rd_now <= 1'b1;
                        end else begin
                            rd_now <= 1'b0;
                        end
                    end
                end
                CLR_ROW, CLR_ALL: begin
                    if (clr_addr != TOTAL_A) begin
                        wren_r   <= 1'b1;
                        addr_r   <= clr_addr;
                        data_r   <= '0;
                        clr_addr <= clr_addr + AW'(1);
                    end else begin
                        wren_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end
endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench: RAM model on port B plus a character-level screen model.
module tb_text_console_ctrl;
    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int CELLS = COLS * ROWS;
    localparam int LOGN  = 16384;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic       busy;

    text_console_if #(.AW(AW)) bus();

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Port-B RAM: write on wren, registered read data one cycle later; every write logged.
    logic [7:0]    mem      [0:(1<<AW)-1];
    logic [AW-1:0] log_addr [0:LOGN-1];
    logic [7:0]    log_data [0:LOGN-1];
    int            wr_count = 0;

    always @(posedge clk) begin
        if (bus.wren === 1'b1) begin
            mem[bus.wraddress]   <= bus.data;
            log_addr[wr_count % LOGN] <= bus.wraddress;
            log_data[wr_count % LOGN] <= bus.data;
            wr_count <= wr_count + 1;
        end
        bus.q <= mem[bus.wraddress];
    end

    // Reference screen model
    logic [7:0] scr [0:ROWS-1][0:COLS-1];
    int ex, ey;
    int total = 0;
    int bad = 0;

    task automatic m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
        ex = 0;
        ey = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[ey][ex] = b;
            ex++;
            if (ex == COLS) begin ex = 0; ey++; end
        end else if (b == 8'h0D) begin
            ex = 0;
        end else if (b == 8'h0A) begin
            ex = 0;
            ey++;
        end else if (b == 8'h08) begin
            if (ex > 0) begin
                ex--;
                scr[ey][ex] = 8'h00;
            end else if (ey > 0) begin
                ex = COLS - 1;
                ey--;
                scr[ey][ex] = 8'h00;
            end
        end else if (b == 8'h0C) begin
            m_clear();
        end
        if (ey == ROWS) begin
            ey = ROWS - 1;
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
        end
    endtask

    function automatic int screen_diffs();
        int d = 0;
        for (int i = 0; i < CELLS; i++)
            if (mem[i] !== scr[i / COLS][i % COLS]) d++;
        return d;
    endfunction

    task automatic wait_idle(input string nm, output int cyc);
        cyc = 0;
        while (bus.ch_ready !== 1'b1 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 6000) begin
            total++; bad++;
            $display("FAIL %s idle_timeout: ch_ready still %b after %0d cycles", nm, bus.ch_ready, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.ch_valid = 1'b1;
        bus.ch_data  = b;
        while (bus.ch_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            total++; bad++;
            $display("FAIL send_timeout: byte %h not accepted", b);
        end
        @(negedge clk);
        bus.ch_valid = 1'b0;
        m_byte(b);
    endtask

    function automatic logic [7:0] rnd_print();
        return 8'($urandom_range(8'h20, 8'h7E));
    endfunction

    // Asserts reset for exactly one edge from the current negedge, then checks the full clear.
    task automatic test_reset();
        int n = 0, seq = 0, c;
        reset = 1'b1;
        bus.ch_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (bus.ch_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL reset_ready_busy: ready=%b busy=%b want ready=0 busy=1", bus.ch_ready, busy);
        end
        total++;
        if (bus.wren !== 1'b0 || bus.wraddress !== '0 || bus.data !== 8'h00) begin
            bad++; $display("FAIL reset_port: wren=%b addr=%0d data=%h want 0/0/00", bus.wren, bus.wraddress, bus.data);
        end
        @(negedge clk);
        while (bus.wren === 1'b1 && n < 3000) begin
            if (bus.wraddress !== AW'(n) || bus.data !== 8'h00 || bus.ch_ready !== 1'b0) seq++;
            n++;
            @(negedge clk);
        end
        total++;
        if (n != CELLS) begin bad++; $display("FAIL clear_len: got %0d writes want %0d", n, CELLS); end
        total++;
        if (seq != 0) begin bad++; $display("FAIL clear_seq: %0d bad cycles want 0", seq); end
        wait_idle("reset", c);
        total++;
        if (c != 0) begin bad++; $display("FAIL clear_ready: ready came %0d cycles after last write want 0", c); end
        m_clear();
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
            bad++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_put_bs();
        logic [7:0]    bytes [3] = '{8'h41, 8'h42, 8'h08};
        logic [AW-1:0] eaddr [3] = '{12'd0, 12'd1, 12'd1};
        logic [7:0]    edata [3] = '{8'h41, 8'h42, 8'h00};
        int c;
        for (int i = 0; i < 3; i++) begin
            wait_idle("put", c);
            bus.ch_valid = 1'b1;
            bus.ch_data  = bytes[i];
            @(negedge clk);
            bus.ch_valid = 1'b0;
            m_byte(bytes[i]);
            total++;
            if (bus.wren !== 1'b1 || bus.wraddress !== eaddr[i] || bus.data !== edata[i] || bus.ch_ready !== 1'b0) begin
                bad++; $display("FAIL put_write[%0d]: wren=%b addr=%0d data=%h ready=%b want 1/%0d/%h/0",
                                i, bus.wren, bus.wraddress, bus.data, bus.ch_ready, eaddr[i], edata[i]);
            end
            @(negedge clk);
            total++;
            if (bus.ch_ready !== 1'b1 || bus.wren !== 1'b0) begin
                bad++; $display("FAIL put_gap[%0d]: ready=%b wren=%b want 1/0", i, bus.ch_ready, bus.wren);
            end
            if (i == 1) begin
                total++;
                if (cursor_x !== 7'd2 || cursor_y !== 5'd0) begin
                    bad++; $display("FAIL ab_cursor: got (%0d,%0d) want (2,0)", cursor_x, cursor_y);
                end
            end
        end
        total++;
        if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin
            bad++; $display("FAIL bs_cursor: got (%0d,%0d) want (1,0)", cursor_x, cursor_y);
        end
        total++;
        if (screen_diffs() != 0) begin bad++; $display("FAIL put_screen: %0d cells differ want 0", screen_diffs()); end
    endtask

    task automatic test_row_fill();
        int c, w0;
        send_byte(8'h0D);
        total++;
        if (bus.ch_ready !== 1'b1 || bus.wren !== 1'b0) begin
            bad++; $display("FAIL cr_no_stall: ready=%b wren=%b want 1/0", bus.ch_ready, bus.wren);
        end
        w0 = wr_count;
        for (int i = 0; i < COLS; i++) send_byte(rnd_print());
        wait_idle("row_fill", c);
        total++;
        if (wr_count - w0 != COLS) begin bad++; $display("FAIL row_fill_writes: got %0d want %0d", wr_count - w0, COLS); end
        total++;
        if (log_addr[(wr_count - 1) % LOGN] !== AW'(COLS - 1)) begin
            bad++; $display("FAIL row_fill_last: got addr %0d want %0d", log_addr[(wr_count - 1) % LOGN], COLS - 1);
        end
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL row_fill_cursor: got (%0d,%0d) busy=%b want (0,1) busy=0", cursor_x, cursor_y, busy);
        end
        total++;
        if (screen_diffs() != 0) begin bad++; $display("FAIL row_fill_screen: %0d cells differ", screen_diffs()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6] = '{8'h07, 8'h0D, 8'h01, 8'h1B, 8'h7F, 8'hC3};
        int c, w0;
        send_byte(8'h58);
        wait_idle("b2b", c);
        w0 = wr_count;
        for (int i = 0; i < 6; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = seq[i];
            @(negedge clk);
            m_byte(seq[i]);
            total++;
            if (bus.ch_ready !== 1'b1 || bus.wren !== 1'b0) begin
                bad++; $display("FAIL b2b[%0d]: ready=%b wren=%b want 1/0", i, bus.ch_ready, bus.wren);
            end
        end
        bus.ch_valid = 1'b0;
        total++;
        if (cursor_x !== 7'(ex) || cursor_y !== 5'(ey) || wr_count != w0) begin
            bad++; $display("FAIL b2b_cursor: got (%0d,%0d) writes=%0d want (%0d,%0d) writes=0",
                            cursor_x, cursor_y, wr_count - w0, ex, ey);
        end
    endtask

    task automatic test_random();
        int c, r;
        logic [7:0] b;
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      b = rnd_print();
            else if (r < 72) b = 8'h0A;
            else if (r < 80) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 255));
                while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D)
                    b = 8'($urandom_range(0, 255));
            end
            send_byte(b);
            wait_idle("random", c);
            total++;
            if (cursor_x !== 7'(ex) || cursor_y !== 5'(ey)) begin
                bad++; $display("FAIL random_cursor[%0d] byte %h: got (%0d,%0d) want (%0d,%0d)", i, b, cursor_x, cursor_y, ex, ey);
            end
            if (i % 25 == 24) begin
                total++;
                if (screen_diffs() != 0) begin bad++; $display("FAIL random_screen[%0d]: %0d cells differ", i, screen_diffs()); end
            end
        end
    endtask

    task automatic test_scroll();
        int c, w0, hd = 0, tl = 0;
        send_byte(8'h0C);
        send_byte(8'h0A);
        for (int i = 0; i < COLS; i++) send_byte(8'h31);
        for (int i = 0; i < ROWS - 3; i++) send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte(rnd_print());
        wait_idle("scroll_setup", c);
        total++;
        if (cursor_x !== 7'd5 || cursor_y !== 5'd29) begin
            bad++; $display("FAIL scroll_setup_cursor: got (%0d,%0d) want (5,29)", cursor_x, cursor_y);
        end
        w0 = wr_count;
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'h0A;
        @(negedge clk);
        bus.ch_valid = 1'b0;
        m_byte(8'h0A);
        wait_idle("scroll", c);
        // Small allowance for pipeline fill around the nominal 2N+COLS cycles.
        total++;
        if (c < 4129 || c > 4140) begin bad++; $display("FAIL scroll_time: got %0d cycles want about 4130", c + 1); end
        total++;
        if (wr_count - w0 != CELLS) begin bad++; $display("FAIL scroll_writes: got %0d want %0d", wr_count - w0, CELLS); end
        for (int i = 0; i < COLS; i++) begin
            if (log_addr[(w0 + i) % LOGN] !== AW'(i) || log_data[(w0 + i) % LOGN] !== 8'h31) hd++;
            if (log_addr[(w0 + CELLS - COLS + i) % LOGN] !== AW'(CELLS - COLS + i) ||
                log_data[(w0 + CELLS - COLS + i) % LOGN] !== 8'h00) tl++;
        end
        total++;
        if (hd != 0) begin bad++; $display("FAIL scroll_first_row: %0d of first 70 writes wrong want 0", hd); end
        total++;
        if (tl != 0) begin bad++; $display("FAIL scroll_row_clear: %0d of last 70 writes wrong want 0", tl); end
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd29 || bus.ch_ready !== 1'b1) begin
            bad++; $display("FAIL scroll_cursor: got (%0d,%0d) ready=%b want (0,29) ready=1", cursor_x, cursor_y, bus.ch_ready);
        end
        total++;
        if (screen_diffs() != 0) begin bad++; $display("FAIL scroll_screen: %0d cells differ", screen_diffs()); end
    endtask

    task automatic test_ff_ignore();
        int c, w0, seq = 0;
        send_byte(8'h0C);
        for (int i = 0; i < 10; i++) send_byte(8'h0A);
        for (int i = 0; i < 10; i++) send_byte(rnd_print());
        wait_idle("ff_setup", c);
        total++;
        if (cursor_x !== 7'd10 || cursor_y !== 5'd10) begin
            bad++; $display("FAIL ff_setup_cursor: got (%0d,%0d) want (10,10)", cursor_x, cursor_y);
        end
        w0 = wr_count;
        send_byte(8'h0C);
        wait_idle("ff", c);
        for (int i = 0; i < CELLS; i++)
            if (log_addr[(w0 + i) % LOGN] !== AW'(i) || log_data[(w0 + i) % LOGN] !== 8'h00) seq++;
        total++;
        if (wr_count - w0 != CELLS || seq != 0) begin
            bad++; $display("FAIL ff_clear: writes=%0d bad=%0d want %0d/0", wr_count - w0, seq, CELLS);
        end
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd0 || screen_diffs() != 0) begin
            bad++; $display("FAIL ff_state: cursor (%0d,%0d) diffs=%0d want (0,0)/0", cursor_x, cursor_y, screen_diffs());
        end
        send_byte(8'h78);
        wait_idle("bel", c);
        w0 = wr_count;
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'h07;
        @(negedge clk);
        bus.ch_valid = 1'b0;
        m_byte(8'h07);
        total++;
        if (bus.ch_ready !== 1'b1 || bus.wren !== 1'b0 || wr_count != w0 || cursor_x !== 7'd1 || cursor_y !== 5'd0) begin
            bad++; $display("FAIL bel: ready=%b wren=%b writes=%0d cursor (%0d,%0d) want 1/0/0 (1,0)",
                            bus.ch_ready, bus.wren, wr_count - w0, cursor_x, cursor_y);
        end
    endtask

    task automatic test_reset_mid_scroll();
        int c, w0;
        send_byte(8'h0C);
        for (int i = 0; i < ROWS - 1; i++) begin
            send_byte(rnd_print());
            send_byte(8'h0A);
        end
        wait_idle("mid_setup", c);
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'h0A;
        @(negedge clk);
        bus.ch_valid = 1'b0;
        repeat (499) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_scroll_busy: busy=%b want 1", busy); end
        test_reset();
        w0 = wr_count;
        repeat (4200) @(negedge clk);
        total++;
        if (wr_count != w0) begin bad++; $display("FAIL mid_scroll_stale: %0d writes after clear want 0", wr_count - w0); end
        total++;
        if (screen_diffs() != 0) begin bad++; $display("FAIL mid_scroll_screen: %0d cells nonzero", screen_diffs()); end
    endtask

    initial begin
        bus.ch_valid = 1'b0;
        bus.ch_data  = 8'h00;
        m_clear();
        test_reset();
        test_put_bs();
        test_row_fill();
        test_back_to_back();
        test_random();
        test_scroll();
        test_ff_ignore();
        test_reset_mid_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
